// File: rtl/gcd_rr_arbiter.sv
// Round-robin arbiter that time-shares one GCD core among NREQ requesters.
// Captures the winner's operands, launches the core, returns the result or a zero-operand/timeout error.
module gcd_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              core_go,
  output logic [W-1:0]      core_x,
  output logic [W-1:0]      core_y,
  input  logic              core_done,
  input  logic [W-1:0]      core_result,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, gidx_q, gidx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d, rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d, core_x_q, core_x_d, core_y_q, core_y_d;
  logic            rsp_err_q, rsp_err_d, core_go_q, core_go_d, busy_q, busy_d;

  logic            found, to_resp;
  logic [IW-1:0]   win, cand;
  logic [W-1:0]    sel_x, sel_y;

  // Search starts just after the last granted index, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    sel_x = '0;
    sel_y = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (IW'(j) == win) begin
        sel_x = x_in[j*W +: W];
        sel_y = y_in[j*W +: W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    core_x_d   = core_x_q;
    core_y_d   = core_y_q;
    core_go_d  = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    to_resp    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          gidx_d       = win;
          core_x_d     = sel_x;
          core_y_d     = sel_y;
          cnt_d        = '0;
          if (sel_x == '0 || sel_y == '0) begin
            rsp_err_d = 1'b1;
            to_resp   = 1'b1;
            state_d   = S_RESP;
          end else begin
            core_go_d = 1'b1;
            state_d   = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // core_done is tested first so it wins over a coincident timeout.
        if (core_done) begin
          rsp_data_d = core_result;
          to_resp    = 1'b1;
          state_d    = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_err_d = 1'b1;
          to_resp   = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        ptr_d   = gidx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = to_resp ? grant_d : '0;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      ptr_q       <= IW'(NREQ - 1);
      gidx_q      <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      core_go_q   <= 1'b0;
      core_x_q    <= '0;
      core_y_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      core_go_q   <= core_go_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign core_go   = core_go_q;
  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// Directed bench for gcd_rr_arbiter with a behavioural GCD core and a response scoreboard.
module tb_gcd_rr_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 4;
  localparam int unsigned TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              clr;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] x_in = '0;
  logic [NREQ*W-1:0] y_in = '0;
  logic [NREQ-1:0]   grant, rsp_valid;
  logic [W-1:0]      rsp_data, core_x, core_y;
  logic              rsp_err, core_go, busy;
  logic              core_done = 1'b0;
  logic [W-1:0]      core_result = '0;

  gcd_rr_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .req(req), .x_in(x_in), .y_in(y_in),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_go(core_go), .core_x(core_x), .core_y(core_y),
    .core_done(core_done), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int go_cnt = 0;
  int rsp_cnt = 0;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    logic       err;
  } exp_t;
  exp_t sb[$];

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    for (int i = 0; i < 64 && b != '0; i++) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic [W-1:0] d, input logic e);
    exp_t x;
    x.idx = idx; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] x, input logic [W-1:0] y);
    x_in[idx*W +: W] = x;
    y_in[idx*W +: W] = y;
  endtask

  task automatic wait_rsp(input int limit, output int lat);
    lat = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        lat = n;
        break;
      end
    end
  endtask

  // Behavioural core: done arrives core_delay cycles after the go cycle.
  int           core_delay = 5;
  logic         core_hang = 1'b0;
  logic         cm_act;
  int           cm_left;
  logic [W-1:0] cm_res;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      cm_act    <= 1'b0;
      cm_left   <= 0;
      cm_res    <= '0;
      core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (core_go) begin
        if (core_delay <= 1) begin
          core_done   <= ~core_hang;
          core_result <= gcd_f(core_x, core_y);
        end else begin
          cm_act  <= 1'b1;
          cm_left <= core_delay - 1;
          cm_res  <= gcd_f(core_x, core_y);
        end
      end else if (cm_act) begin
        if (cm_left <= 1) begin
          cm_act <= 1'b0;
          if (!core_hang) begin
            core_done   <= 1'b1;
            core_result <= cm_res;
          end
        end else begin
          cm_left <= cm_left - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (core_go === 1'b1) go_cnt++;
    if (clr === 1'b0 && rsp_valid !== '0) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.idx);
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int go0, rsp0;

    clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_rsp_err", 32'(rsp_err), 32'(0));
    chk("rst_core_go", 32'(core_go), 32'(0));
    chk("rst_core_xy", {24'(0), core_x, core_y}, 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    clr = 1'b0;
    @(negedge clk);

    // Single request, operands changed mid-operation.
    core_delay = 5;
    set_ops(0, 4'd12, 4'd8);
    push(0, gcd_f(4'd12, 4'd8), 1'b0);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_go", 32'(core_go), 32'(1));
    chk("t1_grant", 32'(grant), 32'(4'b0001));
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_core_x", 32'(core_x), 32'(12));
    chk("t1_core_y", 32'(core_y), 32'(8));
    set_ops(0, 4'd7, 4'd5);
    @(negedge clk);
    chk("t1_go_pulse", 32'(core_go), 32'(0));
    chk("t1_x_held", 32'(core_x), 32'(12));
    wait_rsp(200, lat);
    chk("t1_latency", 32'(lat), 32'(5));
    req = '0;
    @(negedge clk);
    chk("t1_grant_clr", 32'(grant), 32'(0));
    chk("t1_idle", 32'(busy), 32'(0));

    // Zero operand: direct error response, no launch.
    go0 = go_cnt;
    set_ops(2, 4'd0, 4'd5);
    push(2, 4'd0, 1'b1);
    req = 4'b0100;
    wait_rsp(200, lat);
    chk("t3_latency", 32'(lat), 32'(1));
    chk("t3_no_go", 32'(core_go), 32'(0));
    chk("t3_busy", 32'(busy), 32'(1));
    req = '0;
    @(negedge clk);
    chk("t3_go_count", 32'(go_cnt), 32'(go0));
    chk("t3_idle", 32'(busy), 32'(0));

    // Core never completes: timeout TIMEOUT cycles after core_go.
    core_hang = 1'b1;
    set_ops(3, 4'd6, 4'd4);
    push(3, 4'd0, 1'b1);
    req = 4'b1000;
    @(negedge clk);
    chk("t4_go", 32'(core_go), 32'(1));
    wait_rsp(200, lat);
    chk("t4_timeout_lat", 32'(lat), 32'(TIMEOUT));
    req = '0;
    @(negedge clk);
    chk("t4_idle", 32'(busy), 32'(0));

    // Next request after timeout, at minimum latency.
    core_hang  = 1'b0;
    core_delay = 1;
    set_ops(0, 4'd15, 4'd10);
    push(0, gcd_f(4'd15, 4'd10), 1'b0);
    req = 4'b0001;
    wait_rsp(200, lat);
    chk("t4_min_latency", 32'(lat), 32'(3));
    req = '0;
    @(negedge clk);

    // req dropped during WAIT; done coincides with timeout.
    core_delay = TIMEOUT - 1;
    set_ops(1, 4'd14, 4'd6);
    push(1, gcd_f(4'd14, 4'd6), 1'b0);
    req = 4'b0010;
    repeat (10) @(negedge clk);
    req = '0;
    wait_rsp(200, lat);
    chk("t6_latency", 32'(lat), 32'(TIMEOUT - 9));
    @(negedge clk);

    // clr while in WAIT: immediate drop, no response.
    core_delay = 20;
    rsp0 = rsp_cnt;
    set_ops(2, 4'd9, 4'd3);
    req = 4'b0100;
    repeat (6) @(negedge clk);
    chk("t5_busy_before", 32'(busy), 32'(1));
    clr = 1'b1;
    req = '0;
    #1;
    chk("t5_grant", 32'(grant), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_go", 32'(core_go), 32'(0));
    @(negedge clk);
    clr = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_no_rsp", 32'(rsp_cnt), 32'(rsp0));

    // All four requesting: order 0,1,2,3,0 from the reset pointer.
    core_delay = 3;
    for (int i = 0; i < 4; i++) set_ops(i, 4'd9, 4'd6);
    for (int k = 0; k < 5; k++) push(k % 4, gcd_f(4'd9, 4'd6), 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(200, lat);
      chk("t2_latency", 32'(lat), (k == 0) ? 32'(5) : 32'(6));
      if (k == 4) req = '0;
    end
    repeat (3) @(negedge clk);
    chk("t2_idle", 32'(busy), 32'(0));
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
